// File: rtl/systolic_pkg.sv
// Shared sizing, row types and pointer helper for the systolic matrix-multiply engine.
package systolic_pkg;

  localparam int unsigned DATASIZE            = 8;
  localparam int unsigned ARRAYWIDTH          = 16;
  localparam int unsigned ARRAYHEIGHT         = 16;  // must equal ARRAYWIDTH
  localparam int unsigned OUTPUT_BUF_DATASIZE = 32;
  localparam int unsigned DSP_DELAY           = 1;

  localparam int unsigned PTR_W = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(ARRAYWIDTH + 1);

  typedef logic [DATASIZE*ARRAYWIDTH-1:0]            act_row_t;
  typedef logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] res_row_t;

  // Row pointer increment that wraps modulo the array size.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ARRAYWIDTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single MAC cell: stationary weight, act passes right, psum passes down, both DSP_DELAY deep.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATASIZE-1:0]            act_in,
  input  logic [OUTPUT_BUF_DATASIZE-1:0] psum_in,
  input  logic [DATASIZE-1:0]            w_in,
  input  logic                           w_en,
  output logic [DATASIZE-1:0]            act_out,
  output logic [OUTPUT_BUF_DATASIZE-1:0] psum_out,
  output logic [DATASIZE-1:0]            w_out
);

  localparam int unsigned DW = DATASIZE;
  localparam int unsigned AW = OUTPUT_BUF_DATASIZE;
  localparam int unsigned PW = 2 * DATASIZE;
  localparam int unsigned D  = DSP_DELAY;

  logic [DW-1:0]        w_q;
  logic [DW-1:0]        act_pipe  [D];
  logic [AW-1:0]        psum_pipe [D];
  logic signed [PW-1:0] prod_c;

  assign prod_c = $signed(act_in) * $signed(w_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      for (int m = 0; m < D; m++) begin
        act_pipe[m]  <= '0;
        psum_pipe[m] <= '0;
      end
    end else begin
      if (w_en) w_q <= w_in;
      act_pipe[0]  <= act_in;
      psum_pipe[0] <= psum_in + AW'(prod_c);
      for (int m = 1; m < D; m++) begin
        act_pipe[m]  <= act_pipe[m-1];
        psum_pipe[m] <= psum_pipe[m-1];
      end
    end
  end

  assign act_out  = act_pipe[D-1];
  assign psum_out = psum_pipe[D-1];
  assign w_out    = w_q;

endmodule

// File: rtl/systolic_array_top.sv
// Weight-stationary N x N systolic matmul with ReLU; sequencing driven entirely by external strobes.
module systolic_array_top
  import systolic_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      weight_buffer_load_en,
  input  logic                                      weight_buffer_out_en,
  input  logic                                      write_weight_en,
  input  logic                                      input_buffer_load_en,
  input  logic                                      input_buffer_out_en,
  input  logic                                      output_buffer_load_en,
  input  logic                                      output_buffer_out_en,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
  output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_top
);

  localparam int unsigned N  = ARRAYWIDTH;
  localparam int unsigned DW = DATASIZE;
  localparam int unsigned AW = OUTPUT_BUF_DATASIZE;
  localparam int unsigned D  = DSP_DELAY;

  // Weight buffer: row store read combinationally so row 0 of the grid can take it the same cycle.
  act_row_t         wbuf [N];
  logic [PTR_W-1:0] w_wr, w_rd;
  act_row_t         wb_out_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) wbuf[r] <= '0;
      w_wr <= '0;
      w_rd <= '0;
    end else begin
      if (weight_buffer_load_en) begin
        wbuf[w_wr] <= in_weight;
        w_wr       <= next_ptr(w_wr);
      end
      if (weight_buffer_out_en) w_rd <= next_ptr(w_rd);
    end
  end

  assign wb_out_c = weight_buffer_out_en ? wbuf[w_rd] : '0;

  // Input buffer: emits vectors 0..N-1 once per load, zeros afterwards.
  act_row_t         ibuf [N];
  logic [PTR_W-1:0] i_wr;
  logic [CNT_W-1:0] i_cnt;
  act_row_t         ib_out_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) ibuf[r] <= '0;
      i_wr  <= '0;
      i_cnt <= '0;
    end else begin
      if (input_buffer_load_en) begin
        ibuf[i_wr] <= in_act;
        i_wr       <= next_ptr(i_wr);
        i_cnt      <= '0;
      end else if (input_buffer_out_en && (i_cnt < CNT_W'(N))) begin
        i_cnt <= i_cnt + 1'b1;
      end
    end
  end

  assign ib_out_c = (input_buffer_out_en && (i_cnt < CNT_W'(N))) ? ibuf[i_cnt[PTR_W-1:0]] : '0;

  logic [DW-1:0] act_h  [N][N+1];
  logic [AW-1:0] psum_v [N+1][N];
  logic [DW-1:0] w_v    [N+1][N];

  // Input skew: lane i lags lane 0 by i*D cycles.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign act_h[0][0] = ib_out_c[DW-1:0];
    end else begin : g_pipe
      localparam int unsigned L = i * D;
      logic [DW-1:0] pipe [L];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int m = 0; m < L; m++) pipe[m] <= '0;
        end else begin
          pipe[0] <= ib_out_c[DW*i +: DW];
          for (int m = 1; m < L; m++) pipe[m] <= pipe[m-1];
        end
      end
      assign act_h[i][0] = pipe[L-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_top_edge
    assign psum_v[0][j] = '0;
    assign w_v[0][j]    = wb_out_c[DW*j +: DW];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe u_pe (
        .clk      (clk),
        .rst      (rst),
        .act_in   (act_h[i][j]),
        .psum_in  (psum_v[i][j]),
        .w_in     (w_v[i][j]),
        .w_en     (write_weight_en),
        .act_out  (act_h[i][j+1]),
        .psum_out (psum_v[i+1][j]),
        .w_out    (w_v[i+1][j])
      );
    end
  end

  // ReLU then deskew: column j is delayed (N-1-j)*D so every column of a row lines up.
  logic [AW-1:0] relu_c [N];
  res_row_t      dsk_c;

  for (genvar j = 0; j < N; j++) begin : g_deskew
    assign relu_c[j] = psum_v[N][j][AW-1] ? '0 : psum_v[N][j];
    localparam int unsigned L = (N - 1 - j) * D;
    if (L == 0) begin : g_direct
      assign dsk_c[AW*j +: AW] = relu_c[j];
    end else begin : g_pipe
      logic [AW-1:0] pipe [L];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int m = 0; m < L; m++) pipe[m] <= '0;
        end else begin
          pipe[0] <= relu_c[j];
          for (int m = 1; m < L; m++) pipe[m] <= pipe[m-1];
        end
      end
      assign dsk_c[AW*j +: AW] = pipe[L-1];
    end
  end

  // Output buffer shifts in one row per load cycle; the last N rows of the window are rows 0..N-1.
  res_row_t         obuf [N];
  logic [CNT_W-1:0] o_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) obuf[r] <= '0;
      o_cnt   <= '0;
      out_top <= '0;
    end else begin
      if (output_buffer_load_en) begin
        for (int r = 0; r < N - 1; r++) obuf[r] <= obuf[r+1];
        obuf[N-1] <= dsk_c;
        o_cnt     <= '0;
      end
      if (output_buffer_out_en) begin
        if (o_cnt < CNT_W'(N)) begin
          out_top <= obuf[o_cnt[PTR_W-1:0]];
          o_cnt   <= o_cnt + 1'b1;
        end else begin
          out_top <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_top.sv
// Directed scoreboard bench for systolic_array_top: matmul + ReLU against a behavioural model.
module tb_systolic_array_top;
  import systolic_pkg::*;

  localparam int N        = ARRAYWIDTH;
  localparam int D        = DSP_DELAY;
  localparam int AW       = OUTPUT_BUF_DATASIZE;
  localparam int T0       = 2 * N;
  localparam int LOAD_S   = T0 + D * N;
  localparam int LOAD_LEN = D * (N - 1) + N;
  localparam int OUT_S    = LOAD_S + LOAD_LEN;
  localparam int OUT_E    = OUT_S + N - 1;

  logic     clk = 1'b0;
  logic     rst;
  logic     weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic     input_buffer_load_en, input_buffer_out_en;
  logic     output_buffer_load_en, output_buffer_out_en;
  act_row_t in_weight, in_act;
  res_row_t out_top;

  systolic_array_top dut (
    .clk                   (clk),
    .rst                   (rst),
    .weight_buffer_load_en (weight_buffer_load_en),
    .weight_buffer_out_en  (weight_buffer_out_en),
    .write_weight_en       (write_weight_en),
    .input_buffer_load_en  (input_buffer_load_en),
    .input_buffer_out_en   (input_buffer_out_en),
    .output_buffer_load_en (output_buffer_load_en),
    .output_buffer_out_en  (output_buffer_out_en),
    .in_weight             (in_weight),
    .in_act                (in_act),
    .out_top               (out_top)
  );

  always #5 clk = ~clk;

  int       a_m  [N][N];
  int       w_ld [N][N];
  res_row_t exp_q [$];
  res_row_t last_exp;
  int       vectors = 0;
  int       miscompares = 0;

  // Row k of relu(A*W), where W[i] is the weight row loaded (N-1-i)-th.
  function automatic res_row_t model_row(input int k);
    res_row_t r;
    int acc;
    r = '0;
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += a_m[k][i] * w_ld[N-1-i][j];
      r[AW*j +: AW] = (acc < 0) ? '0 : 32'(acc);
    end
    return r;
  endfunction

  function automatic act_row_t pack_w(input int r);
    act_row_t v;
    for (int j = 0; j < N; j++) v[8*j +: 8] = 8'(w_ld[r][j]);
    return v;
  endfunction

  function automatic act_row_t pack_a(input int r);
    act_row_t v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(a_m[r][i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input res_row_t obs, input res_row_t expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    weight_buffer_load_en = 1'b0;
    weight_buffer_out_en  = 1'b0;
    write_weight_en       = 1'b0;
    input_buffer_load_en  = 1'b0;
    input_buffer_out_en   = 1'b0;
    output_buffer_load_en = 1'b0;
    output_buffer_out_en  = 1'b0;
    in_weight             = '0;
    in_act                = '0;
  endtask

  // Full load/compute/drain pass; optionally aborted by a reset at cycle 40.
  task automatic run(input string name, input bit abort_at_40);
    int k;
    for (int c = 0; c <= OUT_E; c++) begin
      idle_inputs();
      if (c < N) begin
        weight_buffer_load_en = 1'b1;
        in_weight             = pack_w(c);
      end
      if (c >= N && c < 2 * N) begin
        weight_buffer_out_en = 1'b1;
        write_weight_en      = 1'b1;
        input_buffer_load_en = 1'b1;
        in_act               = pack_a(c - N);
      end
      if (c >= T0 && c < T0 + N) input_buffer_out_en = 1'b1;
      if (c >= LOAD_S && c < OUT_S) output_buffer_load_en = 1'b1;
      if (c >= OUT_S) begin
        output_buffer_out_en = 1'b1;
        exp_q.push_back(model_row(c - OUT_S));
      end
      if (abort_at_40 && c == 40) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({name, "_after_reset"}, out_top, '0);
        exp_q.delete();
        idle_inputs();
        return;
      end
      tick();
      if (output_buffer_out_en) begin
        k = c - OUT_S;
        last_exp = exp_q.pop_front();
        check($sformatf("%s_row%0d", name, k), out_top, last_exp);
      end
    end
    idle_inputs();
    tick();
    check({name, "_hold"}, out_top, last_exp);
    output_buffer_out_en = 1'b1;
    tick();
    check({name, "_past_end"}, out_top, '0);
    idle_inputs();
    tick();
  endtask

  task automatic setup_identity();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) w_ld[r][j] = (j == N - 1 - r) ? 1 : 0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) a_m[k][i] = k + i;
  endtask

  initial begin
    byte b;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_state", out_top, '0);
    rst = 1'b0;
    tick();

    setup_identity();
    run("identity", 1'b0);

    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        w_ld[r][j] = -1;
        a_m[r][j]  = 1;
      end
    run("neg_weights", 1'b0);

    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        w_ld[r][j] = 127;
        a_m[r][j]  = (r % 2 == 0) ? -128 : 127;
      end
    run("extremes", 1'b0);
    check("extremes_model_pos", model_row(1), {N{32'd258064}});

    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        b = byte'($urandom);
        w_ld[r][j] = b;
        b = byte'($urandom);
        a_m[r][j] = b;
      end
    run("random", 1'b0);

    setup_identity();
    run("abort", 1'b1);
    run("identity_rerun", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
